// File: rtl/dds_pkg.sv
// dds_pkg: shared defaults and FSM state types for the DDS frame collector.
package dds_pkg;
    localparam int DEF_NUM_CH = 32;
    localparam int DEF_DW     = 16;
    localparam int DEF_CW     = 5;

    typedef enum logic {C_IDLE, C_FILL} cap_state_e;
    typedef enum logic {R_IDLE, R_SEND} rd_state_e;
endpackage

// File: rtl/dds_frame_bank.sv
// dds_frame_bank: two-bank frame storage, one write port, one registered read port.
module dds_frame_bank
    import dds_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DW     = DEF_DW,
    parameter int CW     = DEF_CW
)(
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic          wbank,
    input  logic [CW-1:0] widx,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic          rbank,
    input  logic [CW-1:0] ridx,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [2][NUM_CH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[wbank][widx] <= wdata;
    end

    // The read register doubles as the output data register, so it holds while re is low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rdata_q <= '0;
        else if (re) rdata_q <= mem_q[rbank][ridx];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dds_frame_collector.sv
// dds_frame_collector: assembles channel frames into a ping-pong buffer and replays them.
// Optional DDS_COLLECT_STATS_EN builds the frame_count/drop_count counters.
module dds_frame_collector
    import dds_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DW     = DEF_DW,
    parameter int CW     = DEF_CW
)(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    input  logic [CW-1:0]        in_channel,
    input  logic signed [DW-1:0] in_sample,
    input  logic                 sync,
    input  logic                 clear_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [CW-1:0]        out_channel,
    output logic                 out_last,
    output logic                 overflow,
    output logic                 seq_err,
    output logic [15:0]          frame_count,
    output logic [15:0]          drop_count
);
    cap_state_e    cap_q;
    rd_state_e     rd_q;
    logic [CW-1:0] exp_ch_q;
    logic          wsel_q, rsel_q;
    logic [1:0]    full_q, full_d;
    logic          out_valid_q, out_last_q, overflow_q, seq_err_q;
    logic [CW-1:0] out_channel_q;

    logic          cap_ev, start_ok, hit, we, frame_done, drop, brk;
    logic          fire, last_fire, chain, start_rd, re, rbank;
    logic [CW-1:0] ridx;

    // Capture decisions use the registered full flags, so a buffer freed this edge still looks full.
    assign cap_ev     = in_valid && !sync;
    assign start_ok   = in_channel == '0 && !full_q[wsel_q];
    assign hit        = cap_q == C_FILL && in_channel == exp_ch_q;
    assign we         = cap_ev && (hit || start_ok);
    assign frame_done = cap_ev && hit && exp_ch_q == CW'(NUM_CH - 1);
    assign drop       = cap_ev && cap_q == C_IDLE && in_channel == '0 && full_q[wsel_q];
    assign brk        = cap_ev && cap_q == C_FILL && !hit;

    assign fire      = out_valid_q && out_ready && !sync;
    assign last_fire = fire && out_last_q;
    assign chain     = last_fire && full_q[!rsel_q];
    assign start_rd  = !sync && rd_q == R_IDLE && full_q[rsel_q];
    assign re        = start_rd || (fire && (!out_last_q || chain));
    assign rbank     = last_fire ? !rsel_q : rsel_q;
    assign ridx      = (start_rd || last_fire) ? '0 : CW'(out_channel_q + 1'b1);

    always_comb begin
        full_d = full_q;
        if (last_fire) full_d[rsel_q] = 1'b0;
        if (frame_done) full_d[wsel_q] = 1'b1;
    end

    dds_frame_bank #(.NUM_CH(NUM_CH), .DW(DW), .CW(CW)) u_bank (
        .clk   (clk),
        .resetn(resetn),
        .we    (we),
        .wbank (wsel_q),
        .widx  (in_channel),
        .wdata (in_sample),
        .re    (re),
        .rbank (rbank),
        .ridx  (ridx),
        .rdata (out_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_q    <= C_IDLE;
            exp_ch_q <= '0;
            wsel_q   <= 1'b0;
        end else if (sync) begin
            cap_q  <= C_IDLE;
            wsel_q <= 1'b0;
        end else if (frame_done) begin
            cap_q  <= C_IDLE;
            wsel_q <= ~wsel_q;
        end else if (we) begin
            cap_q    <= C_FILL;
            exp_ch_q <= CW'(in_channel + 1'b1);
        end else if (brk) begin
            cap_q <= C_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_q          <= R_IDLE;
            rsel_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_last_q    <= 1'b0;
        end else if (sync) begin
            rd_q        <= R_IDLE;
            rsel_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (start_rd) begin
            rd_q          <= R_SEND;
            out_valid_q   <= 1'b1;
            out_channel_q <= '0;
            out_last_q    <= 1'b0;
        end else if (last_fire) begin
            rsel_q        <= ~rsel_q;
            out_channel_q <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= chain;
            rd_q          <= chain ? R_SEND : R_IDLE;
        end else if (fire) begin
            out_channel_q <= CW'(out_channel_q + 1'b1);
            out_last_q    <= out_channel_q == CW'(NUM_CH - 2);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_q     <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            full_q     <= sync ? 2'b00 : full_d;
            overflow_q <= drop || (overflow_q && !clear_flags);
            seq_err_q  <= brk || (seq_err_q && !clear_flags);
        end
    end

`ifdef DDS_COLLECT_STATS_EN
    logic [15:0] frame_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + 16'(last_fire);
            drop_cnt_q  <= drop_cnt_q + 16'(drop);
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

    assign out_valid   = out_valid_q;
    assign out_channel = out_channel_q;
    assign out_last    = out_last_q;
    assign overflow    = overflow_q;
    assign seq_err     = seq_err_q;
endmodule

// File: doc/dds_frame_collector.md
# dds_frame_collector

Downstream stage of the multichannel DDS core. Consumes the time-multiplexed sample stream (one sample per clock, tagged with its channel index and a valid flag), assembles complete channel frames into a ping-pong buffer, and replays each frame over a valid/ready stream toward the DAC/packetiser. It detects channel-sequence breaks and frame overruns, so a stalled consumer never produces torn frames.

## Interface
- `NUM_CH`, 32: channels per frame; legal range 2..32.
- `DW`, 16: sample width, signed two's complement.
- `CW`, 5: channel index width; must satisfy `2**CW >= NUM_CH`.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample qualifier from the DDS core.
- `in_channel`  in  CW  channel index of `in_sample`.
- `in_sample`  in  DW  signed sine sample.
- `sync`  in  1  synchronous flush, active high, level-sampled.
- `clear_flags`  in  1  clears sticky flags, active high.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DW  sample being replayed.
- `out_channel`  out  CW  channel index of `out_data`.
- `out_last`  out  1  high on the word with channel `NUM_CH-1`.
- `overflow`  out  1  sticky; a frame was dropped because no buffer was free.
- `seq_err`  out  1  sticky; channel index broke the expected sequence.
- `frame_count`  out  16  frames delivered (only with the macro; see Configuration).
- `drop_count`  out  16  frames dropped (only with the macro; see Configuration).

## Operation
- Two frame buffers, B0 and B1, each `NUM_CH` x `DW`, each with a `full` flag. `wsel` and `rsel` both reset to B0.
- Capture FSM:
  - **C_IDLE**:
    - Ignores every input except `in_valid` with `in_channel==0`.
    - If `full[wsel]==0`: write index 0 and go to C_FILL with `expect=1`.
    - If `full[wsel]==1`: set `overflow`, increment `drop_count`, stay in C_IDLE. The rest of that frame is discarded.
  - **C_FILL**, on `in_valid`:
    - If `in_channel==expect`: write the sample and increment `expect`.
    - If the written index is `NUM_CH-1`: set `full[wsel]`, toggle `wsel`, go to C_IDLE.
    - If `in_channel!=expect`: set `seq_err` and discard the partial frame.
      - If `in_channel==0` and `full[wsel]==0`: write it as index 0 and stay in C_FILL with `expect=1`.
      - Otherwise: go to C_IDLE.
  - `in_valid` low in any state: no change.
- Readout FSM:
  - **R_IDLE**: when `full[rsel]==1`, load word 0 into the output registers and go to R_SEND.
  - **R_SEND**: present word `idx`.
    - On `out_valid && out_ready`, load word `idx+1` at the same edge. Throughput is one word per clock.
    - When handshaking `NUM_CH-1`: clear `full[rsel]`, toggle `rsel`, increment `frame_count`.
    - If the other buffer is already full, go directly to word 0 of that buffer with no bubble. Otherwise go to R_IDLE.
- Holding rule: while `out_valid && !out_ready`, `out_data`, `out_channel` and `out_last` are held stable.
- `sync` (highest priority, one cycle):
  - Capture FSM goes to C_IDLE; readout FSM goes to R_IDLE.
  - Both `full` flags clear; `wsel` and `rsel` go to B0.
  - `out_valid` drops the next edge, even mid-handshake. This is the only permitted violation of the holding rule.
  - Sticky flags and counters are unaffected.
- `clear_flags` clears `overflow` and `seq_err`. A set event in the same cycle wins, and the flag stays 1.
- Counters wrap modulo 2^16.

## Timing
- Reset values:
  - `out_valid`, `out_data`, `out_channel`, `out_last`, `overflow`, `seq_err`, `frame_count`, `drop_count` are all 0.
  - Both FSMs idle, `full` flags 0, `wsel`/`rsel` at B0.
- Latency: the last sample (channel `NUM_CH-1`) captured at edge E gives `full` set at E, word 0 loaded at E+1, and `out_valid` high after E+1.
- The `full` flag is registered:
  - A buffer cleared by readout at edge E is seen as full by capture at edge E.
  - Therefore a channel 0 arriving that cycle for that buffer counts as overflow.
- Sticky flags are visible the cycle after the triggering edge.
- Reset asserted mid-frame: everything returns to reset values immediately, regardless of `clk`.

## Configuration
- `DDS_COLLECT_STATS_EN` defined: the `frame_count` and `drop_count` registers and ports exist and behave as above.
- Not defined: both ports are tied to 0 and the counter registers are not built. All other behaviour is identical.

## Structure
- Shared package `dds_pkg` holds:
  - `NUM_CH`, `DW` and `CW` defaults.
  - Capture-state enum {C_IDLE, C_FILL}.
  - Readout-state enum {R_IDLE, R_SEND}.
- One sub-module, `dds_frame_bank`: the two-bank storage with one write port (bank, index, data, we) and one synchronous read port (bank, index). The `full` flags and FSMs stay in the top.

## Test plan
- Frame replay: feed channels 0..31 with `sample=ch*100`, `out_ready=1`.
  - Expect 32 words after a 2-edge latency, values 0..3100.
  - `out_last` high only on channel 31; `frame_count=1`.
- Backpressure: `out_ready` toggled 1/0 each cycle.
  - Data is held while stalled and every word is delivered exactly once, in order.
- Overflow: `out_ready=0`, then send three complete frames.
  - The first two are buffered; the third sets `overflow=1` and `drop_count=1`.
  - With `out_ready=1`, frames 1 and 2 are replayed back-to-back with no idle cycle.
- Sequence break: channels 0..9, then 12.
  - Expect `seq_err=1`, no output, and the next clean 0..31 frame delivered intact.
- Sync mid-replay: pulse `sync` at word 5 of the output.
  - `out_valid` is 0 the next cycle and the buffers are empty.
  - A new frame replays starting at channel 0.
- Flag collision: `clear_flags` in the same cycle as a new overflow leaves `overflow=1`. `clear_flags` alone then gives 0.
